// File: rtl/avst_10gb_pkg.sv
// Shared types and widths for the 64-bit Avalon-ST packet FIFO.
//   avst_beat_t : one stored beat {sop, eop, empty, data}, 69 bits packed
//   in_state_t  : input framing FSM states
package avst_10gb_pkg;

  localparam int AVST_DW = 64;
  localparam int EMPTY_W = 3;
  localparam int ERR_W   = 6;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [AVST_DW-1:0] data;
  } avst_beat_t;

  localparam int BEAT_W = $bits(avst_beat_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } in_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) output.
//   clk    : single clock
//   we     : write enable, waddr/wdata written at the rising edge
//   re     : read enable, rdata updated at the rising edge from raddr
// No reset on the array or the read register; contents are only consumed
// after having been written.
module sdp_ram #(
  parameter int WIDTH  = 69,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/avst_pkt_fifo_10gb.sv
// Store-and-forward packet FIFO on the 64-bit Avalon-ST bus.
// Only complete, error-free packets are released downstream; errored,
// truncated and overflowing packets are dropped whole.
//
// Ports:
//   clk_in, reset                 : single clock, async active-high reset
//   asi_in_*                      : sink side, never backpressured
//   aso_out_*                     : source side, ready latency 0
//   pkt_count / drop_count        : wrapping 16-bit statistics
//
// Handshake: a beat moves on the source side in any cycle where
// aso_out_valid and aso_out_ready are both high at the rising edge; while
// valid is high and ready is low, data/sop/eop/empty are held unchanged.
// On the sink side every cycle with asi_in_valid high is a beat
// (asi_in_ready is 1 whenever reset is low).
//
// Pointers are ADDR_WIDTH+1 bits; the extra MSB separates full from empty.
//   wr_ptr     : speculative write position of the packet being received
//   commit_ptr : end of the last committed packet
//   rd_ptr     : next beat to fetch from RAM
// The read side sees commit_ptr through a one-cycle register so a freshly
// committed packet becomes readable the cycle after commit.
module avst_pkt_fifo_10gb
  import avst_10gb_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [AVST_DW-1:0] asi_in_data,
  input  logic               asi_in_valid,
  output logic               asi_in_ready,
  input  logic               asi_in_sop,
  input  logic               asi_in_eop,
  input  logic [EMPTY_W-1:0] asi_in_empty,
  input  logic [ERR_W-1:0]   asi_in_error,
  output logic [AVST_DW-1:0] aso_out_data,
  output logic               aso_out_valid,
  input  logic               aso_out_ready,
  output logic               aso_out_sop,
  output logic               aso_out_eop,
  output logic [EMPTY_W-1:0] aso_out_empty,
  output logic [ERR_W-1:0]   aso_out_error,
  output logic [CNT_W-1:0]   pkt_count,
  output logic [CNT_W-1:0]   drop_count
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  // ---------------------------------------------------------------------
  // Input side: framing FSM, speculative write, commit / rewind
  // ---------------------------------------------------------------------
  in_state_t       state_q, state_d;
  logic            bad_q, bad_d, bad_n;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_q, commit_d;
  logic [PW-1:0]   commit_rd_q;
  logic [PW-1:0]   rd_ptr_q;
  logic            pkt_inc;
  logic [1:0]      drop_inc;
  logic            ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  avst_beat_t      ram_wdata;
  logic            in_err;
  logic [PW-1:0]   used_wr;
  logic [PW-1:0]   used_commit;
  logic            pkt_full;
  logic            start_full;

  assign in_err      = |asi_in_error;
  assign used_wr     = wr_ptr_q - rd_ptr_q;
  assign used_commit = commit_q - rd_ptr_q;
  assign pkt_full    = (used_wr == DEPTH);
  // A new sop always restarts from commit_ptr (discarding any fragment).
  assign start_full  = (used_commit == DEPTH);

  assign ram_wdata.sop   = asi_in_sop;
  assign ram_wdata.eop   = asi_in_eop;
  assign ram_wdata.empty = asi_in_empty;
  assign ram_wdata.data  = asi_in_data;

  always_comb begin
    state_d   = state_q;
    bad_d     = bad_q;
    bad_n     = bad_q | in_err;
    wr_ptr_d  = wr_ptr_q;
    commit_d  = commit_q;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q[ADDR_WIDTH-1:0];
    pkt_inc   = 1'b0;
    drop_inc  = 2'd0;

    if (asi_in_valid) begin
      if (asi_in_sop) begin
        // sop while a packet is open: the open fragment is lost.
        if (state_q != IDLE) drop_inc = 2'd1;
        bad_d = in_err;
        if (start_full) begin
          wr_ptr_d = commit_q;
          if (asi_in_eop) begin
            drop_inc = drop_inc + 2'd1;
            state_d  = IDLE;
          end else begin
            state_d = DROP;
          end
        end else begin
          ram_we    = 1'b1;
          ram_waddr = commit_q[ADDR_WIDTH-1:0];
          if (asi_in_eop) begin
            state_d = IDLE;
            if (in_err) begin
              wr_ptr_d = commit_q;
              drop_inc = drop_inc + 2'd1;
            end else begin
              wr_ptr_d = commit_q + 1'b1;
              commit_d = commit_q + 1'b1;
              pkt_inc  = 1'b1;
            end
          end else begin
            wr_ptr_d = commit_q + 1'b1;
            state_d  = PKT;
          end
        end
      end else begin
        case (state_q)
          IDLE: begin
            // Stray beat outside a packet; a stray eop counts as a fragment.
            if (asi_in_eop) drop_inc = 2'd1;
          end
          PKT: begin
            if (pkt_full) begin
              if (asi_in_eop) begin
                wr_ptr_d = commit_q;
                drop_inc = 2'd1;
                state_d  = IDLE;
              end else begin
                state_d = DROP;
              end
            end else begin
              ram_we = 1'b1;
              bad_d  = bad_n;
              if (asi_in_eop) begin
                state_d = IDLE;
                if (bad_n) begin
                  wr_ptr_d = commit_q;
                  drop_inc = 2'd1;
                end else begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  commit_d = wr_ptr_q + 1'b1;
                  pkt_inc  = 1'b1;
                end
              end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
              end
            end
          end
          DROP: begin
            if (asi_in_eop) begin
              wr_ptr_d = commit_q;
              drop_inc = 2'd1;
              state_d  = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bad_q       <= 1'b0;
      wr_ptr_q    <= '0;
      commit_q    <= '0;
      commit_rd_q <= '0;
      pkt_count   <= '0;
      drop_count  <= '0;
    end else begin
      state_q     <= state_d;
      bad_q       <= bad_d;
      wr_ptr_q    <= wr_ptr_d;
      commit_q    <= commit_d;
      commit_rd_q <= commit_q;
      pkt_count   <= pkt_count + CNT_W'(pkt_inc);
      drop_count  <= drop_count + CNT_W'(drop_inc);
    end
  end

  assign asi_in_ready = ~reset;

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic       rd_en;
  avst_beat_t ram_rdata;

  sdp_ram #(
    .WIDTH  (BEAT_W),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk_in),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (rd_en),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------
  // Output side: RAM read stage -> output register, with a 1-entry skid.
  // At most two beats are ever in flight (RAM stage + out + skid), so a
  // read is issued only if that bound still holds after this cycle's pop.
  // ---------------------------------------------------------------------
  logic       ram_vld_q;
  logic       out_vld_q;
  logic       skid_vld_q;
  avst_beat_t out_q;
  avst_beat_t skid_q;
  logic       pop;
  logic       out_free;
  logic [1:0] occ;
  logic       room;

  assign pop      = out_vld_q & aso_out_ready;
  assign out_free = ~out_vld_q | pop;
  assign occ      = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
  assign room     = (occ < 2'd2) || (pop && (occ == 2'd2));
  assign rd_en    = (rd_ptr_q != commit_rd_q) && room;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      ram_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_q + PW'(rd_en);
      ram_vld_q <= rd_en;
      if (out_free) begin
        if (skid_vld_q) begin
          out_q      <= skid_q;
          out_vld_q  <= 1'b1;
          skid_vld_q <= ram_vld_q;
          if (ram_vld_q) skid_q <= ram_rdata;
        end else if (ram_vld_q) begin
          out_q     <= ram_rdata;
          out_vld_q <= 1'b1;
        end else begin
          out_vld_q <= 1'b0;
        end
      end else if (ram_vld_q) begin
        skid_q     <= ram_rdata;
        skid_vld_q <= 1'b1;
      end
    end
  end

  assign aso_out_valid = out_vld_q;
  assign aso_out_data  = out_q.data;
  assign aso_out_sop   = out_q.sop;
  assign aso_out_eop   = out_q.eop;
  assign aso_out_empty = out_q.empty;
  assign aso_out_error = '0;

endmodule

// File: tb/tb_avst_pkt_fifo_10gb.sv
// Directed bench for avst_pkt_fifo_10gb. Two instances share the input
// data bus: dut_b (default depth) and dut_s (ADDR_WIDTH=4, 16 beats).
module tb_avst_pkt_fifo_10gb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic [2:0]  in_empty = '0;
  logic [5:0]  in_error = '0;
  logic        in_valid_b = 1'b0;
  logic        in_valid_s = 1'b0;
  logic        ready_b = 1'b1;
  logic        ready_s = 1'b1;

  logic        in_ready_b, in_ready_s;
  logic [63:0] out_data_b, out_data_s;
  logic        out_valid_b, out_valid_s;
  logic        out_sop_b, out_sop_s, out_eop_b, out_eop_s;
  logic [2:0]  out_empty_b, out_empty_s;
  logic [5:0]  out_error_b, out_error_s;
  logic [15:0] pkt_b, pkt_s, drop_b, drop_s;

  avst_pkt_fifo_10gb dut_b (
    .clk_in(clk), .reset(reset),
    .asi_in_data(in_data), .asi_in_valid(in_valid_b), .asi_in_ready(in_ready_b),
    .asi_in_sop(in_sop), .asi_in_eop(in_eop), .asi_in_empty(in_empty),
    .asi_in_error(in_error),
    .aso_out_data(out_data_b), .aso_out_valid(out_valid_b), .aso_out_ready(ready_b),
    .aso_out_sop(out_sop_b), .aso_out_eop(out_eop_b), .aso_out_empty(out_empty_b),
    .aso_out_error(out_error_b), .pkt_count(pkt_b), .drop_count(drop_b)
  );

  avst_pkt_fifo_10gb #(.ADDR_WIDTH(4)) dut_s (
    .clk_in(clk), .reset(reset),
    .asi_in_data(in_data), .asi_in_valid(in_valid_s), .asi_in_ready(in_ready_s),
    .asi_in_sop(in_sop), .asi_in_eop(in_eop), .asi_in_empty(in_empty),
    .asi_in_error(in_error),
    .aso_out_data(out_data_s), .aso_out_valid(out_valid_s), .aso_out_ready(ready_s),
    .aso_out_sop(out_sop_s), .aso_out_eop(out_eop_s), .aso_out_empty(out_empty_s),
    .aso_out_error(out_error_s), .pkt_count(pkt_s), .drop_count(drop_s)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitors (sample on the falling edge) ----------------
  logic [68:0] cap_q[$];
  int          cap_cyc_q[$];
  logic [68:0] cap_s_q[$];
  int          hold_viol = 0;
  int          err_viol = 0;
  logic        prev_hold = 1'b0;
  logic [68:0] prev_word = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold &&
          (!out_valid_b || {out_sop_b, out_eop_b, out_empty_b, out_data_b} !== prev_word))
        hold_viol = hold_viol + 1;
      if (out_valid_b && out_error_b != 6'd0) err_viol = err_viol + 1;
      if (out_valid_b && ready_b) begin
        cap_q.push_back({out_sop_b, out_eop_b, out_empty_b, out_data_b});
        cap_cyc_q.push_back(cyc);
      end
      if (out_valid_s && ready_s)
        cap_s_q.push_back({out_sop_s, out_eop_s, out_empty_s, out_data_s});
      prev_hold = out_valid_b && !ready_b;
      prev_word = {out_sop_b, out_eop_b, out_empty_b, out_data_b};
    end
  end

  // ---------------- scoreboard state ----------------
  logic [68:0] exp_q[$];
  logic [68:0] exp_s_q[$];
  int cap_rd = 0;
  int cap_s_rd = 0;
  int n_vec = 0;
  int n_bad = 0;
  int last_eop_cyc = 0;
  bit tog_en = 1'b0;

  task automatic check_vec(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int id, input int b);
    return {16'hC0DE, id[15:0], b[15:0], 16'h5A5A ^ id[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input int sel, input logic sop, input logic eop,
                            input logic [2:0] empty, input logic [5:0] err,
                            input logic [63:0] data);
    @(posedge clk);
    #1;
    if (tog_en) ready_b = ~ready_b;
    in_sop     = sop;
    in_eop     = eop;
    in_empty   = empty;
    in_error   = err;
    in_data    = data;
    in_valid_b = (sel == 0);
    in_valid_s = (sel == 1);
    if (eop) last_eop_cyc = cyc + 1;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    if (tog_en) ready_b = ~ready_b;
    in_valid_b = 1'b0;
    in_valid_s = 1'b0;
    in_sop     = 1'b0;
    in_eop     = 1'b0;
    in_error   = '0;
  endtask

  // err_beat < 0 means no errored beat; fwd pushes the beats as expected output.
  task automatic send_pkt(input int sel, input int id, input int n, input logic [2:0] empty,
                          input int err_beat, input logic [5:0] err_val, input bit fwd);
    for (int b = 0; b < n; b++) begin
      logic        s, e;
      logic [2:0]  em;
      logic [63:0] d;
      s  = (b == 0);
      e  = (b == n - 1);
      em = e ? empty : 3'd0;
      d  = mk_data(id, b);
      drive_beat(sel, s, e, em, (b == err_beat) ? err_val : 6'd0, d);
      if (fwd) begin
        if (sel == 0) exp_q.push_back({s, e, em, d});
        else          exp_s_q.push_back({s, e, em, d});
      end
    end
  endtask

  // Wait (bounded) until all expected beats have left, then a few more
  // cycles so duplicated or extra beats are also caught.
  task automatic wait_drain(input int sel);
    bit done;
    done = 1'b0;
    go_idle();
    for (int i = 0; i < 3000 && !done; i++) begin
      @(posedge clk);
      #1;
      if (tog_en) ready_b = ~ready_b;
      if (sel == 0) done = (cap_q.size() - cap_rd >= exp_q.size()) && !out_valid_b;
      else          done = (cap_s_q.size() - cap_s_rd >= exp_s_q.size()) && !out_valid_s;
    end
    check_vec("drain_done", 69'(done), 69'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      if (tog_en) ready_b = ~ready_b;
    end
  endtask

  task automatic compare_out(input int sel, input string tag);
    int n, m;
    if (sel == 0) begin
      n = cap_q.size() - cap_rd;
      m = exp_q.size();
      check_vec({tag, "_beats"}, 69'(n), 69'(m));
      for (int i = 0; i < n && i < m; i++)
        check_vec($sformatf("%s_beat%0d", tag, i), cap_q[cap_rd + i], exp_q[i]);
      cap_rd = cap_rd + n;
      exp_q.delete();
    end else begin
      n = cap_s_q.size() - cap_s_rd;
      m = exp_s_q.size();
      check_vec({tag, "_beats"}, 69'(n), 69'(m));
      for (int i = 0; i < n && i < m; i++)
        check_vec($sformatf("%s_beat%0d", tag, i), cap_s_q[cap_s_rd + i], exp_s_q[i]);
      cap_s_rd = cap_s_rd + n;
      exp_s_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;

    // Reset state
    #2;
    check_vec("rst_out_valid", 69'(out_valid_b), 69'd0);
    check_vec("rst_in_ready", 69'(in_ready_b), 69'd0);
    check_vec("rst_pkt", 69'(pkt_b), 69'd0);
    check_vec("rst_drop", 69'(drop_b), 69'd0);
    check_vec("rst_out_data", 69'(out_data_b), 69'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_vec("in_ready_after_rst", 69'(in_ready_b), 69'd1);

    // 1: single 8-beat packet, empty=2, ready=1, first beat at eop+3
    ready_b = 1'b1;
    send_pkt(0, 1, 8, 3'd2, -1, 6'd0, 1'b1);
    wait_drain(0);
    lat = (cap_q.size() > cap_rd) ? (cap_cyc_q[cap_rd] - last_eop_cyc) : -1;
    check_vec("t1_latency", 69'(lat), 69'd3);
    compare_out(0, "t1");
    check_vec("t1_pkt", 69'(pkt_b), 69'd1);
    check_vec("t1_drop", 69'(drop_b), 69'd0);

    // 2: error on beat 3 of 10 -> dropped; following clean packet forwarded
    send_pkt(0, 10, 10, 3'd0, 3, 6'h01, 1'b0);
    send_pkt(0, 11, 5, 3'd1, -1, 6'd0, 1'b1);
    wait_drain(0);
    compare_out(0, "t2");
    check_vec("t2_pkt", 69'(pkt_b), 69'd2);
    check_vec("t2_drop", 69'(drop_b), 69'd1);

    // 3: 16-deep instance: 20-beat overflow dropped, 4-beat forwarded,
    //    then an exactly-fitting 16-beat packet with ready held low
    ready_s = 1'b0;
    send_pkt(1, 20, 20, 3'd0, -1, 6'd0, 1'b0);
    go_idle();
    repeat (4) @(posedge clk);
    #1;
    check_vec("t3_ovf_valid", 69'(out_valid_s), 69'd0);
    check_vec("t3_ovf_drop", 69'(drop_s), 69'd1);
    check_vec("t3_ovf_pkt", 69'(pkt_s), 69'd0);
    ready_s = 1'b1;
    send_pkt(1, 21, 4, 3'd3, -1, 6'd0, 1'b1);
    wait_drain(1);
    compare_out(1, "t3a");
    check_vec("t3a_pkt", 69'(pkt_s), 69'd1);
    ready_s = 1'b0;
    send_pkt(1, 22, 16, 3'd4, -1, 6'd0, 1'b1);
    go_idle();
    repeat (4) @(posedge clk);
    #1;
    check_vec("t3b_pkt", 69'(pkt_s), 69'd2);
    check_vec("t3b_drop", 69'(drop_s), 69'd1);
    ready_s = 1'b1;
    wait_drain(1);
    compare_out(1, "t3b");

    // 4: six back-to-back 64 B packets, ready toggling every cycle
    tog_en = 1'b1;
    for (int id = 30; id < 36; id++) send_pkt(0, id, 8, 3'd0, -1, 6'd0, 1'b1);
    wait_drain(0);
    tog_en = 1'b0;
    ready_b = 1'b1;
    compare_out(0, "t4");
    check_vec("t4_pkt", 69'(pkt_b), 69'd8);
    check_vec("t4_drop", 69'(drop_b), 69'd1);
    check_vec("t4_hold", 69'(hold_viol), 69'd0);

    // 5: sop,beat,sop (missing eop) then complete; lone eop; lone mid beat;
    //    single-beat packet
    drive_beat(0, 1'b1, 1'b0, 3'd0, 6'd0, mk_data(40, 0));
    drive_beat(0, 1'b0, 1'b0, 3'd0, 6'd0, mk_data(40, 1));
    send_pkt(0, 41, 4, 3'd6, -1, 6'd0, 1'b1);
    go_idle();
    drive_beat(0, 1'b0, 1'b1, 3'd0, 6'd0, mk_data(42, 0));
    drive_beat(0, 1'b0, 1'b0, 3'd0, 6'd0, mk_data(43, 0));
    send_pkt(0, 44, 1, 3'd5, -1, 6'd0, 1'b1);
    wait_drain(0);
    compare_out(0, "t5");
    check_vec("t5_pkt", 69'(pkt_b), 69'd10);
    check_vec("t5_drop", 69'(drop_b), 69'd3);

    // 6: reset mid-output and mid-packet
    ready_b = 1'b0;
    send_pkt(0, 50, 3, 3'd0, -1, 6'd0, 1'b0);
    go_idle();
    repeat (6) @(posedge clk);
    #1;
    check_vec("t6_pre_valid", 69'(out_valid_b), 69'd1);
    drive_beat(0, 1'b1, 1'b0, 3'd0, 6'd0, mk_data(51, 0));
    drive_beat(0, 1'b0, 1'b0, 3'd0, 6'd0, mk_data(51, 1));
    #3 reset = 1'b1;
    #1;
    check_vec("t6_rst_valid", 69'(out_valid_b), 69'd0);
    check_vec("t6_rst_pkt", 69'(pkt_b), 69'd0);
    check_vec("t6_rst_drop", 69'(drop_b), 69'd0);
    check_vec("t6_rst_in_ready", 69'(in_ready_b), 69'd0);
    in_valid_b = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cap_rd = cap_q.size();
    exp_q.delete();
    ready_b = 1'b1;
    send_pkt(0, 52, 3, 3'd7, -1, 6'd0, 1'b1);
    wait_drain(0);
    compare_out(0, "t6");
    check_vec("t6_pkt", 69'(pkt_b), 69'd1);
    check_vec("t6_drop", 69'(drop_b), 69'd0);
    check_vec("out_error_zero", 69'(err_viol), 69'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
